// File: rtl/operand_demux_if.sv
// ---------------------------------------------------------------------------
// operand_demux_if
//
// Bundles the operand demux handshake and result signals.
//
//   in_data    : operand word from the upstream source (SIZE bits)
//   in_valid   : in_data is valid this cycle
//   in_sel     : destination select, 1 = slot A, 0 = slot B
//   in_ready   : demux can take a word this cycle
//   consume    : downstream has taken the presented pair
//   clear      : synchronous flush of both slots
//   a_out      : registered contents of slot A
//   b_out      : registered contents of slot B
//   a_valid    : slot A holds a captured word
//   b_valid    : slot B holds a captured word
//   pair_valid : both slots held, operand pair presented
//   ovw        : one-cycle pulse after a held slot was rewritten
//
// master : the side that drives operands and control (source/sink)
// slave  : the demux itself
// ---------------------------------------------------------------------------
interface operand_demux_if #(
    parameter int SIZE = 4
);
    logic [SIZE-1:0] in_data;
    logic            in_valid;
    logic            in_sel;
    logic            in_ready;
    logic            consume;
    logic            clear;
    logic [SIZE-1:0] a_out;
    logic [SIZE-1:0] b_out;
    logic            a_valid;
    logic            b_valid;
    logic            pair_valid;
    logic            ovw;

    modport master (
        output in_data,
        output in_valid,
        output in_sel,
        output consume,
        output clear,
        input  in_ready,
        input  a_out,
        input  b_out,
        input  a_valid,
        input  b_valid,
        input  pair_valid,
        input  ovw
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_sel,
        input  consume,
        input  clear,
        output in_ready,
        output a_out,
        output b_out,
        output a_valid,
        output b_valid,
        output pair_valid,
        output ovw
    );
endinterface

// File: rtl/operand_demux.sv
// ---------------------------------------------------------------------------
// operand_demux
//
// Collects two operands, A and B, from a single upstream word stream and
// presents them as a pair. Each accepted word is steered by in_sel into slot A
// (in_sel=1) or slot B (in_sel=0). Once both slots are held the block stalls
// upstream (in_ready=0) until downstream pulses consume. A second write to an
// already-held slot replaces it and raises ovw for one cycle.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset; clears state and both slots
//   bus  : operand_demux_if.slave
//            in_data/in_valid/in_sel/in_ready : upstream handshake
//            consume/clear                    : downstream control
//            a_out/b_out                      : held operands
//            a_valid/b_valid/pair_valid/ovw   : status
// ---------------------------------------------------------------------------
module operand_demux #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    operand_demux_if.slave  bus
);

    // Encoding: bit 0 = slot A held, bit 1 = slot B held, so the valid flags
    // come straight off the state register.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        HAVE_A = 2'b01,
        HAVE_B = 2'b10,
        FULL   = 2'b11
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic            ovw_q;
    logic            ovw_d;
    logic            wr_a;
    logic            wr_b;
    logic            ready;
    logic            accept;

    assign ready  = (state_q != FULL);
    assign accept = bus.in_valid && ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and write-enable decode. clear wins over both accept and
    // consume, and suppresses any slot write in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        ovw_d   = 1'b0;

        if (bus.clear) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        if (bus.in_sel) begin
                            state_d = HAVE_A;
                            wr_a    = 1'b1;
                        end else begin
                            state_d = HAVE_B;
                            wr_b    = 1'b1;
                        end
                    end
                end
                HAVE_A: begin
                    if (accept) begin
                        if (bus.in_sel) begin
                            wr_a  = 1'b1;
                            ovw_d = 1'b1;
                        end else begin
                            state_d = FULL;
                            wr_b    = 1'b1;
                        end
                    end
                end
                HAVE_B: begin
                    if (accept) begin
                        if (bus.in_sel) begin
                            state_d = FULL;
                            wr_a    = 1'b1;
                        end else begin
                            wr_b  = 1'b1;
                            ovw_d = 1'b1;
                        end
                    end
                end
                FULL: begin
                    // Upstream is stalled here; only consume moves us on.
                    if (bus.consume) begin
                        state_d = EMPTY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Operand slots and overwrite pulse. Slots keep their contents on clear
    // and consume; only reset zeroes them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
        end else if (wr_a) begin
            a_q <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q <= '0;
        end else if (wr_b) begin
            b_q <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovw_q <= 1'b0;
        end else begin
            ovw_q <= ovw_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.a_valid    = state_q[0];
    assign bus.b_valid    = state_q[1];
    assign bus.pair_valid = (state_q == FULL);
    assign bus.ovw        = ovw_q;

endmodule

// File: tb/tb_operand_demux.sv
module tb_operand_demux;

    logic clk;
    logic rst;

    operand_demux_if #(.SIZE(4)) if4 ();
    operand_demux_if #(.SIZE(8)) if8 ();

    operand_demux #(.SIZE(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    operand_demux #(.SIZE(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] a;
        logic [7:0] b;
        logic       av;
        logic       bv;
        logic       pv;
        logic       ovw;
        logic       rdy;
    } exp_t;

    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    // Reference model, one entry per DUT instance (0 = SIZE 4, 1 = SIZE 8)
    logic [7:0] m_a   [2];
    logic [7:0] m_b   [2];
    logic       m_av  [2];
    logic       m_bv  [2];
    logic       m_ovw [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int w);
        m_a[w]   = '0;
        m_b[w]   = '0;
        m_av[w]  = 1'b0;
        m_bv[w]  = 1'b0;
        m_ovw[w] = 1'b0;
    endtask

    task automatic model_step(input int w, input bit v, input bit sel,
                              input logic [7:0] d, input bit cons, input bit clr);
        logic [7:0] dd;
        bit         novw;
        dd   = (w == 0) ? {4'h0, d[3:0]} : d;
        novw = 1'b0;
        if (rst) begin
            model_reset(w);
            return;
        end
        if (clr) begin
            m_av[w] = 1'b0;
            m_bv[w] = 1'b0;
        end else if (m_av[w] && m_bv[w]) begin
            if (cons) begin
                m_av[w] = 1'b0;
                m_bv[w] = 1'b0;
            end
        end else if (v) begin
            if (sel) begin
                if (m_av[w]) novw = 1'b1;
                m_a[w]  = dd;
                m_av[w] = 1'b1;
            end else begin
                if (m_bv[w]) novw = 1'b1;
                m_b[w]  = dd;
                m_bv[w] = 1'b1;
            end
        end
        m_ovw[w] = novw;
    endtask

    task automatic push_exp(input int w, input string tag);
        exp_t e;
        e.tag = tag;
        e.a   = m_a[w];
        e.b   = m_b[w];
        e.av  = m_av[w];
        e.bv  = m_bv[w];
        e.pv  = m_av[w] && m_bv[w];
        e.ovw = m_ovw[w];
        e.rdy = !(m_av[w] && m_bv[w]);
        sbq.push_back(e);
    endtask

    task automatic pop_compare(input int w);
        exp_t e;
        logic [7:0] oa, ob;
        logic oav, obv, opv, oovw, ordy;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sbq.pop_front();
        if (w == 0) begin
            oa = {4'h0, if4.a_out}; ob = {4'h0, if4.b_out};
            oav = if4.a_valid; obv = if4.b_valid; opv = if4.pair_valid;
            oovw = if4.ovw; ordy = if4.in_ready;
        end else begin
            oa = if8.a_out; ob = if8.b_out;
            oav = if8.a_valid; obv = if8.b_valid; opv = if8.pair_valid;
            oovw = if8.ovw; ordy = if8.in_ready;
        end
        chk({e.tag, ".a_out"},      oa,            e.a);
        chk({e.tag, ".b_out"},      ob,            e.b);
        chk({e.tag, ".a_valid"},    {7'h0, oav},   {7'h0, e.av});
        chk({e.tag, ".b_valid"},    {7'h0, obv},   {7'h0, e.bv});
        chk({e.tag, ".pair_valid"}, {7'h0, opv},   {7'h0, e.pv});
        chk({e.tag, ".ovw"},        {7'h0, oovw},  {7'h0, e.ovw});
        chk({e.tag, ".in_ready"},   {7'h0, ordy},  {7'h0, e.rdy});
    endtask

    task automatic drive(input int w, input bit v, input bit sel,
                         input logic [7:0] d, input bit cons, input bit clr);
        if4.in_valid = 1'b0; if4.in_sel = 1'b0; if4.in_data = '0;
        if4.consume  = 1'b0; if4.clear  = 1'b0;
        if8.in_valid = 1'b0; if8.in_sel = 1'b0; if8.in_data = '0;
        if8.consume  = 1'b0; if8.clear  = 1'b0;
        if (w == 0) begin
            if4.in_valid = v; if4.in_sel = sel; if4.in_data = d[3:0];
            if4.consume  = cons; if4.clear = clr;
        end else begin
            if8.in_valid = v; if8.in_sel = sel; if8.in_data = d;
            if8.consume  = cons; if8.clear = clr;
        end
    endtask

    // Called at a negedge: drive, predict, let one rising edge pass, compare.
    task automatic step(input int w, input bit v, input bit sel, input logic [7:0] d,
                        input bit cons, input bit clr, input string tag);
        drive(w, v, sel, d, cons, clr);
        model_step(w, v, sel, d, cons, clr);
        push_exp(w, tag);
        @(posedge clk);
        #1;
        pop_compare(w);
        @(negedge clk);
    endtask

    task automatic check_now(input int w, input string tag);
        push_exp(w, tag);
        pop_compare(w);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 8'h0, 0, 0);
        model_reset(0);
        model_reset(1);
        #1;
        check_now(0, "reset4");
        check_now(1, "reset8");

        @(negedge clk);
        rst = 1'b0;

        // Pair capture, full stall, consume
        step(0, 1, 1, 8'h3, 0, 0, "acc_a3");
        step(0, 1, 0, 8'h9, 0, 0, "acc_b9_full");
        step(0, 1, 1, 8'hF, 0, 0, "full_ignore");
        step(0, 0, 0, 8'h0, 1, 0, "consume");
        step(0, 0, 0, 8'h0, 1, 0, "consume_in_empty");

        // Overwrite of slot A, single-cycle ovw
        step(0, 1, 1, 8'h5, 0, 0, "acc_a5");
        step(0, 1, 1, 8'h6, 0, 0, "ovw_a6");
        step(0, 0, 0, 8'h0, 0, 0, "ovw_drop");
        step(0, 0, 0, 8'h0, 1, 0, "consume_in_have_a");
        step(0, 0, 0, 8'h0, 0, 1, "clear_have_a");

        // Clear beats a simultaneous accept
        step(0, 1, 0, 8'h2, 0, 0, "acc_b2");
        step(0, 1, 1, 8'hA, 0, 1, "clear_vs_accept");

        // Overwrite of slot B, then fill
        step(0, 1, 0, 8'h7, 0, 0, "acc_b7");
        step(0, 1, 0, 8'h8, 0, 0, "ovw_b8");
        step(0, 1, 1, 8'h4, 0, 0, "acc_a4_full");
        step(0, 1, 1, 8'hE, 1, 1, "clear_vs_consume");

        // Refill, then asynchronous reset between edges while full
        step(0, 1, 0, 8'h1, 0, 0, "acc_b1");
        step(0, 1, 1, 8'hC, 0, 0, "acc_ac_full");
        #2;
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check_now(0, "async_rst_full");
        step(0, 1, 1, 8'hE, 0, 0, "accept_held_in_rst");
        rst = 1'b0;
        step(0, 1, 0, 8'hB, 0, 0, "first_edge_accept");

        // Reset landing in the middle of an accept cycle
        drive(0, 1, 1, 8'h3, 0, 0);
        #2;
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        check_now(0, "async_rst_accept");
        @(negedge clk);
        drive(0, 0, 0, 8'h0, 0, 0);
        rst = 1'b0;

        // Randomized run on the 8-bit instance
        for (int i = 0; i < 300; i++) begin
            bit v, sel, cons, clr;
            logic [7:0] d;
            v    = ($urandom_range(0, 3) != 0);
            sel  = $urandom_range(0, 1);
            cons = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 9) == 0);
            d    = 8'($urandom);
            step(1, v, sel, d, cons, clr, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_demux.md
OPERAND_DEMUX -- requirements
Module: operand_demux

Interface
REQ-001 Parameter: SIZE, default 4, width in bits of each operand and of the input word.
REQ-002 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  Reset, asynchronous and active-high.
REQ-004 in_data  input  SIZE  Operand word offered by the upstream source.
REQ-005 in_valid  input  1  in_data SHALL be treated as valid in any cycle where this is 1.
REQ-006 in_sel  input  1  Destination select: 1 routes to slot A, 0 routes to slot B (same polarity as the 2:1 operand mux).
REQ-007 consume  input  1  Downstream pulse indicating the captured pair has been taken.
REQ-008 clear  input  1  Synchronous flush of both slots.
REQ-009 in_ready  output  1  The block SHALL accept in_data in this cycle when this is 1.
REQ-010 a_out  output  SIZE  Registered contents of slot A.
REQ-011 b_out  output  SIZE  Registered contents of slot B.
REQ-012 a_valid  output  1  Slot A holds a captured word.
REQ-013 b_valid  output  1  Slot B holds a captured word.
REQ-014 pair_valid  output  1  Both slots are held; the operand pair is presented.
REQ-015 ovw  output  1  Single-cycle pulse on the cycle after an already-valid slot is rewritten.

Function
REQ-016 The FSM SHALL have exactly four states: EMPTY, HAVE_A, HAVE_B, FULL.
REQ-017 State encoding SHALL track the valid flags: a_valid=1 only in HAVE_A or FULL; b_valid=1 only in HAVE_B or FULL; pair_valid=1 only in FULL.
REQ-018 in_ready SHALL be combinational and equal 1 in every state except FULL.
REQ-019 An accept SHALL occur when in_valid=1 and in_ready=1 on a rising edge.
REQ-020 On an accept, in_data SHALL be written to a_out if in_sel=1, otherwise to b_out. The written value SHALL be visible on the following cycle (1-cycle latency).
REQ-021 Accept transitions: EMPTY with sel=1 SHALL go to HAVE_A; EMPTY with sel=0 SHALL go to HAVE_B; HAVE_A with sel=0 SHALL go to FULL; HAVE_B with sel=1 SHALL go to FULL.
REQ-022 An accept to an already-held slot (HAVE_A with sel=1, or HAVE_B with sel=0) SHALL overwrite the slot, keep the state unchanged, and assert ovw for one cycle.
REQ-023 In FULL, in_valid SHALL be ignored and the slots SHALL not change.
REQ-024 consume=1 in FULL SHALL cause a transition to EMPTY on the next edge; a_out and b_out SHALL retain their values.
REQ-025 consume SHALL be ignored in any state other than FULL.
REQ-026 clear=1 SHALL force EMPTY on the next edge, override any simultaneous accept or consume, and leave a_out and b_out unchanged.
REQ-027 Outputs a_out, b_out and the state SHALL change only on an accept, clear, consume or reset.
REQ-028 No data path width conversion: the word SHALL be stored exactly as SIZE bits.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock, force: state EMPTY, a_out=0, b_out=0, a_valid=0, b_valid=0, pair_valid=0, ovw=0, in_ready=1.
REQ-030 A reset asserted mid-operation, including in FULL or during an accept cycle, SHALL discard all held data.
REQ-031 After reset deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-032 After reset, drive data=4'h3/sel=1, then 4'h9/sel=0 -> a_out=3, b_out=9, pair_valid=1, in_ready=0 after the 2nd edge.
REQ-033 In FULL, drive in_valid=1 with data=4'hF -> a_out/b_out remain 3/9; then pulse consume -> EMPTY, in_ready=1, a_out/b_out still 3/9.
REQ-034 Drive data=4'h5/sel=1, then 4'h6/sel=1 -> a_out=6, state HAVE_A, ovw=1 for exactly one cycle.
REQ-035 In HAVE_B, assert clear together with in_valid=1/sel=1 -> next state EMPTY, no write to a_out.
REQ-036 Assert rst asynchronously between edges while in FULL -> all outputs reach reset values before the next edge.
REQ-037 With SIZE=8, run a randomized accept/consume/clear sequence checked against a reference model of the four states -> no mismatch.
